mem_1r1w_port_arbiter: RTL and testbench
========================================

// Module: mem_1r1w_port_arbiter
// PURPOSE
// - Shares one 1R1W block memory (byte-write-enabled write port, fixed-latency read port) among PORTS requesters.
// - Sits between several memory-side adapters (AXI slave adapter, DMA engine, core port) and a single BRAM instance.
// - Runs independent round-robin write and read arbiters, each burst-locked on *_last.
// - Routes read data back to the issuing requester through a credit-guarded response FIFO.
// PARAMETERS
// - DATA_WIDTH      32  memory word width in bits
// - ADDR_WIDTH      16  memory address width
// - STRB_WIDTH      DATA_WIDTH/8  byte enables per word
// - PORTS           2   number of requesters (2..8)
// - READ_LATENCY    1   memory mem_ren -> mem_dout latency in cycles (1 or 2)
// - RESP_FIFO_DEPTH 4   response FIFO entries; power of two, >= READ_LATENCY+1
// PORTS
// - clk            in   1               clock
// - rst_n          in   1               asynchronous, active-low reset
// - wr_req_valid   in   PORTS           write beat valid, one bit per requester
// - wr_req_ready   out  PORTS           write beat accepted
// - wr_req_addr    in   PORTS*ADDR_WIDTH  write word address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - wr_req_data    in   PORTS*DATA_WIDTH  write data
// - wr_req_strb    in   PORTS*STRB_WIDTH  byte enables
// - wr_req_last    in   PORTS           last beat of write burst; releases write grant
// - rd_req_valid   in   PORTS           read request valid
// - rd_req_ready   out  PORTS           read request accepted
// - rd_req_addr    in   PORTS*ADDR_WIDTH  read word address
// - rd_req_last    in   PORTS           last beat of read burst; releases read grant
// - rd_resp_valid  out  PORTS           response valid, one-hot at most
// - rd_resp_ready  in   PORTS           response accept
// - rd_resp_data   out  DATA_WIDTH      response data, shared by all requesters
// - rd_resp_last   out  1               rd_req_last value carried with the beat
// - mem_wen        out  STRB_WIDTH      memory byte write enables
// - mem_wr_addr    out  ADDR_WIDTH      memory write address
// - mem_din        out  DATA_WIDTH      memory write data
// - mem_ren        out  1               memory read enable
// - mem_rd_addr    out  ADDR_WIDTH      memory read address
// - mem_dout       in   DATA_WIDTH      memory read data, valid READ_LATENCY cycles after mem_ren
// BEHAVIOUR
// - Reset values (async on rst_n low): wr_req_ready=0, rd_req_ready=0, rd_resp_valid=0, mem_wen=0, mem_ren=0.
//   - Reset clears both FSMs to IDLE, both RR pointers to PORTS-1, all grants to 0, the read pipeline valids, FIFO pointers and the credit count.
//   - Mux outputs (addr/din/rd_resp_data) follow grant 0 / FIFO slot 0; they are don't-care while their enable is low.
// - Write FSM, states IDLE and BUSY:
//   - IDLE: if any wr_req_valid, wr_grant <= first valid index after wr_ptr (cyclic); go to BUSY. No beat is accepted in IDLE (1-cycle bubble).
//   - BUSY: wr_req_ready[wr_grant]=1 and all other bits 0.
//   - On valid&ready: mem_wen = wr_req_strb[grant] in the same cycle (combinational), mem_wr_addr and mem_din are muxed from the granted requester.
//   - If wr_req_last is set on that beat: wr_ptr <= wr_grant; go to IDLE.
// - Read FSM, states IDLE and BUSY: same as the write FSM, except rd_req_ready[rd_grant] = BUSY && credit_ok.
//   - credit_ok = (inflight + fifo_count) < RESP_FIFO_DEPTH.
//   - Handshake drives mem_ren=1 and mem_rd_addr = granted address in the same cycle.
// - Read return path:
//   - A READ_LATENCY-deep shift register carries {valid, port id, last}.
//   - At its output, {mem_dout, id, last} is pushed into the FIFO. The push is never refused, which the credit rule guarantees.
// - Response FIFO:
//   - When non-empty, rd_resp_valid[head.id]=1 and rd_resp_data/rd_resp_last come from the head entry.
//   - Pop on rd_resp_valid & rd_resp_ready[head.id]. Responses return in issue order across all ports.
//   - Same-cycle push and pop keeps the count unchanged. A full FIFO with no pop means credit_ok=0, so no read issues.
// - Counter widths: inflight and fifo_count are $clog2(RESP_FIFO_DEPTH+1) bits; FIFO pointers wrap modulo depth.
// - Concurrency and hazards:
//   - Read and write paths are fully concurrent.
//   - Read-during-write to the same address returns the memory's native behaviour; no forwarding.
//   - Single-beat bursts (last on the first beat) release the grant after one beat.
// - Reset asserted mid-burst or with reads in flight: those responses are dropped and never delivered; requesters are reset alongside.
// STRUCTURE
// - No shared package. FSM encodings (IDLE=1'b0, BUSY=1'b1) are localparams; the round-robin pick is a local function.
// - One sub-module, mem_arb_resp_fifo: synchronous FIFO, async active-low reset, width DATA_WIDTH+$clog2(PORTS)+1, exposes count.
// TESTING
// - Single write, port0 addr 0x10, data 0xA5A5A5A5, strb 0xF, last=1 -> grant cycle, then ready, mem_wen=0xF, mem_wr_addr=0x10 for 1 cycle.
// - Both ports request write bursts of 4 -> port0 gets all 4 beats contiguously, 1 bubble, then port1 gets 4; next contention grants port0.
// - Port1 reads 3 words with rd_resp_ready=1, READ_LATENCY=1 -> 3 responses on rd_resp_valid[1], last on the 3rd, data = memory contents.
// - Port0 issues 8 reads, rd_resp_ready=0 -> exactly 4 accepted, rd_req_ready stays 0; raising ready drains 4, then the remaining 4 issue.
// - Interleaved bursts: port0 reads 2, then port1 reads 2 -> rd_resp_valid order 0,0,1,1 with the correct data per port.
// - Assert rst_n low with 2 reads in flight -> no rd_resp_valid after release; a fresh read returns correctly with full credits.

Source files
------------

// File: rtl/mem_arb_resp_fifo.sv
// Response FIFO for the 1R1W port arbiter.
// Holds {read data, port id, last} in issue order; exposes occupancy.
module mem_arb_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    assign head_data = slots[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/mem_1r1w_port_arbiter.sv
// Shares one 1R1W block memory among several requesters with
// burst-locked round-robin write/read arbiters and in-order read return.
module mem_1r1w_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int PORTS           = 2,
    parameter int READ_LATENCY    = 1,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            wr_req_valid,
    output logic [PORTS-1:0]            wr_req_ready,
    input  logic [PORTS*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] wr_req_data,
    input  logic [PORTS*STRB_WIDTH-1:0] wr_req_strb,
    input  logic [PORTS-1:0]            wr_req_last,
    input  logic [PORTS-1:0]            rd_req_valid,
    output logic [PORTS-1:0]            rd_req_ready,
    input  logic [PORTS*ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [PORTS-1:0]            rd_req_last,
    output logic [PORTS-1:0]            rd_resp_valid,
    input  logic [PORTS-1:0]            rd_resp_ready,
    output logic [DATA_WIDTH-1:0]       rd_resp_data,
    output logic                        rd_resp_last,
    output logic [STRB_WIDTH-1:0]       mem_wen,
    output logic [ADDR_WIDTH-1:0]       mem_wr_addr,
    output logic [DATA_WIDTH-1:0]       mem_din,
    output logic                        mem_ren,
    output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]       mem_dout
);

    localparam int ID_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_W   = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_WIDTH + ID_W + 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    // First requesting index strictly after ptr, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [PORTS-1:0] req,
        input logic [ID_W-1:0]  ptr
    );
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(ptr) + k) % PORTS;
            if (!found && req[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic            wr_state;
    logic            wr_state_nxt;
    logic [ID_W-1:0] wr_grant;
    logic [ID_W-1:0] wr_grant_nxt;
    logic [ID_W-1:0] wr_ptr;
    logic [ID_W-1:0] wr_ptr_nxt;
    logic            wr_fire;

    logic            rd_state;
    logic            rd_state_nxt;
    logic [ID_W-1:0] rd_grant;
    logic [ID_W-1:0] rd_grant_nxt;
    logic [ID_W-1:0] rd_ptr;
    logic [ID_W-1:0] rd_ptr_nxt;
    logic            rd_fire;
    logic            credit_ok;

    logic [READ_LATENCY-1:0] pipe_v;
    logic [ID_W-1:0]         pipe_id   [READ_LATENCY];
    logic                    pipe_last [READ_LATENCY];
    logic [CNT_W-1:0]        inflight;

    logic               fifo_push;
    logic [ENTRY_W-1:0] fifo_push_data;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic [DATA_WIDTH-1:0] head_data;
    logic [ID_W-1:0]       head_id;
    logic                  head_last;

    // Write arbiter
    assign wr_fire = (wr_state == S_BUSY) && wr_req_valid[wr_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= S_IDLE;
            wr_grant <= '0;
            wr_ptr   <= ID_W'(PORTS - 1);
        end else begin
            wr_state <= wr_state_nxt;
            wr_grant <= wr_grant_nxt;
            wr_ptr   <= wr_ptr_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_grant_nxt = wr_grant;
        wr_ptr_nxt   = wr_ptr;
        unique case (wr_state)
            S_IDLE: begin
                if (|wr_req_valid) begin
                    wr_grant_nxt = rr_pick(wr_req_valid, wr_ptr);
                    wr_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (wr_fire && wr_req_last[wr_grant]) begin
                    wr_ptr_nxt   = wr_grant;
                    wr_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_req_ready = '0;
        if (wr_state == S_BUSY) begin
            wr_req_ready[wr_grant] = 1'b1;
        end
        mem_wen = '0;
        if (wr_fire) begin
            mem_wen = wr_req_strb[wr_grant*STRB_WIDTH +: STRB_WIDTH];
        end
        mem_wr_addr = wr_req_addr[wr_grant*ADDR_WIDTH +: ADDR_WIDTH];
        mem_din     = wr_req_data[wr_grant*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read arbiter; a beat may only issue if its response has a slot
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count})
                     < (CNT_W + 1)'(RESP_FIFO_DEPTH);
    assign rd_fire = (rd_state == S_BUSY) && credit_ok
                   && rd_req_valid[rd_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= S_IDLE;
            rd_grant <= '0;
            rd_ptr   <= ID_W'(PORTS - 1);
        end else begin
            rd_state <= rd_state_nxt;
            rd_grant <= rd_grant_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_grant_nxt = rd_grant;
        rd_ptr_nxt   = rd_ptr;
        unique case (rd_state)
            S_IDLE: begin
                if (|rd_req_valid) begin
                    rd_grant_nxt = rr_pick(rd_req_valid, rd_ptr);
                    rd_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (rd_fire && rd_req_last[rd_grant]) begin
                    rd_ptr_nxt   = rd_grant;
                    rd_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_req_ready = '0;
        if (rd_state == S_BUSY) begin
            rd_req_ready[rd_grant] = credit_ok;
        end
        mem_ren     = rd_fire;
        mem_rd_addr = rd_req_addr[rd_grant*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Tags travel alongside the memory's fixed read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id[i]   <= '0;
                pipe_last[i] <= 1'b0;
            end
        end else begin
            pipe_v[0]    <= rd_fire;
            pipe_id[0]   <= rd_grant;
            pipe_last[0] <= rd_req_last[rd_grant];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_id[i]   <= pipe_id[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (rd_fire && !fifo_push) begin
            inflight <= inflight + 1'b1;
        end else if (!rd_fire && fifo_push) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign fifo_push      = pipe_v[READ_LATENCY-1];
    assign fifo_push_data = {mem_dout,
                             pipe_id[READ_LATENCY-1],
                             pipe_last[READ_LATENCY-1]};

    mem_arb_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_data, head_id, head_last} = fifo_head;
    assign fifo_pop = !fifo_empty && rd_resp_ready[head_id];

    always_comb begin
        rd_resp_valid = '0;
        if (!fifo_empty) begin
            rd_resp_valid[head_id] = 1'b1;
        end
        rd_resp_data = head_data;
        rd_resp_last = head_last;
    end

endmodule

// File: tb/tb_mem_1r1w_port_arbiter.sv
// Directed bench for mem_1r1w_port_arbiter with a 1-cycle BRAM model.
// Hand-computed expectations for arbitration order, credits and reset.
module tb_mem_1r1w_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_req_valid;
    logic [1:0]  wr_req_ready;
    logic [31:0] wr_req_addr;
    logic [63:0] wr_req_data;
    logic [7:0]  wr_req_strb;
    logic [1:0]  wr_req_last;
    logic [1:0]  rd_req_valid;
    logic [1:0]  rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [1:0]  rd_req_last;
    logic [1:0]  rd_resp_valid;
    logic [1:0]  rd_resp_ready;
    logic [31:0] rd_resp_data;
    logic        rd_resp_last;
    logic [3:0]  mem_wen;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_din;
    logic        mem_ren;
    logic [15:0] mem_rd_addr;
    logic [31:0] mem_dout;

    logic [31:0] bram [0:255];

    int tests  = 0;
    int failed = 0;

    logic [15:0] ra [2][8];
    int          rn [2];
    int          rb [2];
    int          rstart [2];
    logic [31:0] exp_d [8];
    int          exp_p [8];
    logic        exp_l [8];
    int          exp_n;
    int          nr;
    int          b0;
    int          b1;

    logic [1:0] wr_exp [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0] rv3 [8] = '{2'd0, 2'd0, 2'd0, 2'd2,
                            2'd2, 2'd2, 2'd0, 2'd0};

    mem_1r1w_port_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_strb   (wr_req_strb),
        .wr_req_last   (wr_req_last),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_last   (rd_req_last),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .rd_resp_last  (rd_resp_last),
        .mem_wen       (mem_wen),
        .mem_wr_addr   (mem_wr_addr),
        .mem_din       (mem_din),
        .mem_ren       (mem_ren),
        .mem_rd_addr   (mem_rd_addr),
        .mem_dout      (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wen[b]) begin
                bram[mem_wr_addr[7:0]][b*8 +: 8] <= mem_din[b*8 +: 8];
            end
        end
        if (mem_ren) begin
            mem_dout <= bram[mem_rd_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req_valid  = '0;
        wr_req_addr   = '0;
        wr_req_data   = '0;
        wr_req_strb   = '0;
        wr_req_last   = '0;
        rd_req_valid  = '0;
        rd_req_addr   = '0;
        rd_req_last   = '0;
        rd_resp_ready = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic rd_drive(input int c);
        int idx;
        for (int p = 0; p < 2; p++) begin
            idx = (rb[p] < 8) ? rb[p] : 7;
            rd_req_valid[p] = (c >= rstart[p]) && (rb[p] < rn[p]);
            rd_req_addr[p*16 +: 16] = ra[p][idx];
            rd_req_last[p] = (rb[p] == rn[p] - 1);
        end
    endtask

    task automatic rd_accept(input string tag);
        for (int p = 0; p < 2; p++) begin
            if (rd_req_valid[p] && rd_req_ready[p]) begin
                chk($sformatf("%s_ren_p%0d", tag, p), mem_ren, 1);
                chk($sformatf("%s_raddr_p%0d_%0d", tag, p, rb[p]),
                    mem_rd_addr, ra[p][rb[p]]);
                rb[p]++;
            end
        end
    endtask

    task automatic resp_step(input string tag);
        if ((rd_resp_valid & rd_resp_ready) != 2'b00) begin
            if (nr < exp_n) begin
                chk($sformatf("%s_port%0d", tag, nr),
                    rd_resp_valid, 64'(1) << exp_p[nr]);
                chk($sformatf("%s_data%0d", tag, nr),
                    rd_resp_data, exp_d[nr]);
                chk($sformatf("%s_last%0d", tag, nr),
                    rd_resp_last, exp_l[nr]);
            end else begin
                chk($sformatf("%s_extra%0d", tag, nr), rd_resp_valid, 0);
            end
            nr++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_ren", mem_ren, 0);
        do_reset();

        // single write, then a partial-strobe write to the same word
        wr_req_valid = 2'b01;
        wr_req_addr[15:0] = 16'h0010;
        wr_req_data[31:0] = 32'hA5A5A5A5;
        wr_req_strb[3:0]  = 4'hF;
        wr_req_last = 2'b01;
        #1;
        chk("w1_idle_ready", wr_req_ready, 0);
        chk("w1_idle_wen", mem_wen, 0);
        tick();
        chk("w1_ready", wr_req_ready, 2'b01);
        chk("w1_wen", mem_wen, 4'hF);
        chk("w1_addr", mem_wr_addr, 16'h0010);
        chk("w1_din", mem_din, 32'hA5A5A5A5);
        tick();
        wr_req_data[31:0] = 32'h12345678;
        wr_req_strb[3:0]  = 4'h3;
        #1;
        chk("w2_bubble_ready", wr_req_ready, 0);
        chk("w2_bubble_wen", mem_wen, 0);
        tick();
        chk("w2_wen", mem_wen, 4'h3);
        chk("w2_din", mem_din, 32'h12345678);
        tick();
        wr_req_valid = 2'b00;
        #1;
        chk("w2_done_wen", mem_wen, 0);
        chk("w2_done_ready", wr_req_ready, 0);

        // contending 4-beat write bursts
        do_reset();
        b0 = 0;
        b1 = 0;
        wr_req_strb = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            wr_req_valid[0] = (b0 < 4);
            wr_req_valid[1] = (b1 < 4);
            wr_req_addr[15:0]  = 16'h0020 + 16'(b0);
            wr_req_addr[31:16] = 16'h0030 + 16'(b1);
            wr_req_data[31:0]  = 32'h100 + 32'(b0);
            wr_req_data[63:32] = 32'h200 + 32'(b1);
            wr_req_last[0] = (b0 == 3);
            wr_req_last[1] = (b1 == 3);
            #1;
            chk($sformatf("wb_ready_c%0d", c), wr_req_ready, wr_exp[c]);
            if (wr_req_valid[0] && wr_req_ready[0]) begin
                chk($sformatf("wb_addr0_%0d", b0), mem_wr_addr,
                    16'h0020 + 16'(b0));
                chk($sformatf("wb_wen0_%0d", b0), mem_wen, 4'hF);
                b0++;
            end
            if (wr_req_valid[1] && wr_req_ready[1]) begin
                chk($sformatf("wb_addr1_%0d", b1), mem_wr_addr,
                    16'h0030 + 16'(b1));
                chk($sformatf("wb_din1_%0d", b1), mem_din,
                    32'h200 + 32'(b1));
                b1++;
            end
            tick();
        end
        chk("wb_beats0", b0, 4);
        chk("wb_beats1", b1, 4);

        // next contention goes back to port 0
        wr_req_valid = 2'b11;
        wr_req_addr  = {16'h0041, 16'h0040};
        wr_req_data  = {32'h401, 32'h400};
        wr_req_last  = 2'b11;
        #1;
        chk("wc_idle", wr_req_ready, 0);
        tick();
        chk("wc_grant_p0", wr_req_ready, 2'b01);
        chk("wc_addr_p0", mem_wr_addr, 16'h0040);
        tick();
        wr_req_valid = 2'b10;
        #1;
        chk("wc_bubble", wr_req_ready, 0);
        tick();
        chk("wc_grant_p1", wr_req_ready, 2'b10);
        chk("wc_addr_p1", mem_wr_addr, 16'h0041);
        tick();
        wr_req_valid = 2'b00;

        // port 1 reads three words
        rn = '{0, 3};
        rb = '{0, 0};
        rstart = '{0, 0};
        ra[1][0] = 16'h0020;
        ra[1][1] = 16'h0021;
        ra[1][2] = 16'h0022;
        exp_n = 3;
        nr = 0;
        exp_p = '{1, 1, 1, 0, 0, 0, 0, 0};
        exp_d[0] = 32'h100;
        exp_d[1] = 32'h101;
        exp_d[2] = 32'h102;
        exp_l = '{0, 0, 1, 0, 0, 0, 0, 0};
        rd_resp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            rd_drive(c);
            #1;
            chk($sformatf("r3_valid_c%0d", c), rd_resp_valid, rv3[c]);
            rd_accept("r3");
            resp_step("r3");
            tick();
        end
        chk("r3_count", nr, 3);
        chk("r3_issued", rb[1], 3);

        // eight reads against a stalled response side
        rn = '{8, 0};
        rb = '{0, 0};
        ra[0] = '{16'h20, 16'h21, 16'h22, 16'h23,
                  16'h30, 16'h31, 16'h32, 16'h33};
        exp_n = 8;
        nr = 0;
        exp_p = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_d = '{32'h100, 32'h101, 32'h102, 32'h103,
                  32'h200, 32'h201, 32'h202, 32'h203};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
        rd_resp_ready = 2'b00;
        for (int c = 0; c < 10; c++) begin
            rd_drive(c);
            #1;
            rd_accept("r8");
            tick();
        end
        rd_drive(10);
        #1;
        chk("r8_accepted", rb[0], 4);
        chk("r8_ready_blocked", rd_req_ready, 0);
        chk("r8_ren_blocked", mem_ren, 0);
        chk("r8_head_valid", rd_resp_valid, 2'b01);
        chk("r8_head_data", rd_resp_data, 32'h100);
        rd_resp_ready = 2'b11;
        for (int c = 10; c < 40; c++) begin
            rd_drive(c);
            #1;
            rd_accept("r8");
            resp_step("r8");
            tick();
            if (nr == 8) break;
        end
        chk("r8_drained", nr, 8);
        chk("r8_issued", rb[0], 8);

        // port 0 burst then port 1 burst
        rn = '{2, 2};
        rb = '{0, 0};
        rstart = '{0, 1};
        ra[0][0] = 16'h0010;
        ra[0][1] = 16'h0040;
        ra[1][0] = 16'h0041;
        ra[1][1] = 16'h0022;
        exp_n = 4;
        nr = 0;
        exp_p = '{0, 0, 1, 1, 0, 0, 0, 0};
        exp_d[0] = 32'hA5A55678;
        exp_d[1] = 32'h400;
        exp_d[2] = 32'h401;
        exp_d[3] = 32'h102;
        exp_l = '{0, 1, 0, 1, 0, 0, 0, 0};
        for (int c = 0; c < 16; c++) begin
            rd_drive(c);
            #1;
            rd_accept("ri");
            resp_step("ri");
            tick();
            if (nr == 4) break;
        end
        chk("ri_count", nr, 4);

        // reset with two reads in flight
        rn = '{0, 2};
        rb = '{0, 0};
        rstart = '{0, 0};
        ra[1][0] = 16'h0021;
        ra[1][1] = 16'h0023;
        rd_resp_ready = 2'b00;
        for (int c = 0; c < 10; c++) begin
            rd_drive(c);
            #1;
            rd_accept("rr");
            tick();
            if (rb[1] == 2) break;
        end
        chk("rr_issued", rb[1], 2);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rr_in_rst_valid", rd_resp_valid, 0);
        chk("rr_in_rst_ren", mem_ren, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_resp_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rr_dropped_c%0d", c), rd_resp_valid, 0);
        end
        rn = '{1, 0};
        rb = '{0, 0};
        ra[0][0] = 16'h0023;
        exp_n = 1;
        nr = 0;
        exp_p[0] = 0;
        exp_d[0] = 32'h103;
        exp_l[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rd_drive(c);
            #1;
            if (c == 1) begin
                chk("rr_full_credit", rd_req_ready, 2'b01);
            end
            rd_accept("rf");
            resp_step("rf");
            tick();
        end
        chk("rf_count", nr, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
